uart_rx: RTL

Serial UART receiver; the receive-side counterpart of the team's transmit path and parity generator. Samples an asynchronous serial line at mid-bit using a clocks-per-bit counter, deserialises LSB-first data, checks the optional parity bit and the stop bit, and presents each received word with a one-cycle valid strobe plus error flags to the downstream host logic.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync.sv | 28 ++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame constants
// and the parity helper used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  localparam int unsigned C_DEF_WIDTH        = 8;
  localparam int unsigned C_DEF_CLKS_PER_BIT = 16;
  localparam int unsigned C_MAX_WIDTH        = 9;

  // Expected parity bit for a zero-extended data word; parity_type 1 = odd.
  function automatic logic parity_bit(input logic [C_MAX_WIDTH-1:0] data,
                                      input logic                   parity_type);
    return parity_type ^ (^data);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value
// is a parameter so an idle-high serial line does not look like a start bit.
module uart_sync #(
  parameter logic G_RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_r;
  logic sync_r;

  // Metastability chain: two back-to-back flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_r <= G_RESET_VAL;
      sync_r <= G_RESET_VAL;
    end else begin
      meta_r <= i_d;
      sync_r <= meta_r;
    end
  end

  assign o_q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB-first deserialiser, stop/parity checks.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned G_WIDTH        = C_DEF_WIDTH,
  parameter logic        G_PARITY_TYPE  = 1'b1,
  parameter int unsigned G_CLKS_PER_BIT = C_DEF_CLKS_PER_BIT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx,
  output logic [G_WIDTH-1:0] o_data,
  output logic               o_valid,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam int unsigned CW = $clog2(G_CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(G_WIDTH + 1);

  localparam logic [CW-1:0] C_CNT_LAST = CW'(G_CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_CNT_HALF = CW'(G_CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] C_BIT_LAST = BW'(G_WIDTH - 1);

  logic               rx_s;
  rx_state_t          state_r, state_nxt_s;
  logic [CW-1:0]      cnt_r, cnt_nxt_s;
  logic [BW-1:0]      bit_idx_r, bit_idx_nxt_s;
  logic [G_WIDTH-1:0] shift_r, shift_nxt_s;
  logic               strobe_s;
  logic [G_WIDTH-1:0] data_r;
  logic               valid_r;
  logic               perr_r;
  logic               ferr_r;
  logic               busy_r;
`ifdef UART_RX_PARITY_EN
  logic               par_rx_r, par_rx_nxt_s;
`endif

  uart_sync #(.G_RESET_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  // Next-state, counter and shift-register logic for the receive FSM.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    strobe_s      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_rx_nxt_s  = par_rx_r;
`endif
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = '0;
        if (!rx_s) state_nxt_s = ST_START;
        else       state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (cnt_r == C_CNT_HALF) begin
          cnt_nxt_s     = '0;
          bit_idx_nxt_s = '0;
          // A start bit that is high again at its centre was a glitch.
          if (rx_s) state_nxt_s = ST_IDLE;
          else      state_nxt_s = ST_DATA;
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_r == C_CNT_LAST) begin
          cnt_nxt_s     = '0;
          shift_nxt_s   = {rx_s, shift_r[G_WIDTH-1:1]};
          bit_idx_nxt_s = bit_idx_r + 1'b1;
          if (bit_idx_r == C_BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            state_nxt_s = ST_STOP;
`endif
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_r == C_CNT_LAST) begin
          cnt_nxt_s    = '0;
          par_rx_nxt_s = rx_s;
          state_nxt_s  = ST_STOP;
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_r == C_CNT_LAST) begin
          cnt_nxt_s = '0;
          strobe_s  = 1'b1;
          // Leaving at mid-stop gives half a bit of slack for a back-to-back start.
          if (rx_s) state_nxt_s = ST_IDLE;
          else      state_nxt_s = ST_BREAK;
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end
      ST_BREAK: begin
        cnt_nxt_s = '0;
        if (rx_s) state_nxt_s = ST_IDLE;
        else      state_nxt_s = ST_BREAK;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, datapath and registered output update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= '0;
      shift_r   <= '0;
      data_r    <= '0;
      valid_r   <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_rx_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      valid_r   <= strobe_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
`ifdef UART_RX_PARITY_EN
      par_rx_r  <= par_rx_nxt_s;
`endif
      if (strobe_s) begin
        data_r <= shift_r;
        ferr_r <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        perr_r <= par_rx_r ^ parity_bit(C_MAX_WIDTH'(shift_r), G_PARITY_TYPE);
`else
        perr_r <= 1'b0;
`endif
      end else begin
        data_r <= data_r;
        ferr_r <= ferr_r;
        perr_r <= perr_r;
      end
    end
  end

  assign o_data       = data_r;
  assign o_valid      = valid_r;
  assign o_parity_err = perr_r;
  assign o_frame_err  = ferr_r;
  assign o_busy       = busy_r;

endmodule
